// File: rtl/uart_tx_framer.sv
// uart_tx_framer: collects a payload byte stream over valid/ready into a
// single buffer, then feeds the UART transmitter one frame
// SOF, LEN, payload..., [CHK], one byte per transmitter completion.
// Optional feature macro: UART_FRAMER_CHECKSUM_EN adds the trailing
// mod-256 checksum byte (LEN plus all payload bytes).
//
// Handshake: a payload byte moves on a rising edge where i_valid and o_ready
// are both high; i_data/i_last are only looked at in that cycle, and
// o_ready depends only on registered state (no combinational path from
// i_valid).
module uart_tx_framer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] SOF   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_busy,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  localparam logic [2:0] COLLECT   = 3'd0;
  localparam logic [2:0] SEND_SOF  = 3'd1;
  localparam logic [2:0] SEND_LEN  = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam logic [2:0] SEND_CHK  = 3'd4;
`endif
  localparam logic [2:0] DONE      = 3'd5;

  // State that follows the last payload byte.
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam logic [2:0] AFTER_DATA = SEND_CHK;
`else
  localparam logic [2:0] AFTER_DATA = DONE;
`endif

  logic [7:0]    mem [DEPTH];
  logic [2:0]    state;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_idx;
  logic          issued;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic [7:0]    cur_byte;
  logic [7:0]    len_byte;
  logic          accept;
  logic          in_send;
  logic          issue_now;
  logic          done_now;
`ifdef UART_FRAMER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  assign accept   = i_valid && (state == COLLECT);
  assign len_byte = 8'(wr_cnt);

`ifdef UART_FRAMER_CHECKSUM_EN
  assign in_send = (state == SEND_SOF) || (state == SEND_LEN) ||
                   (state == SEND_DATA) || (state == SEND_CHK);
`else
  assign in_send = (state == SEND_SOF) || (state == SEND_LEN) ||
                   (state == SEND_DATA);
`endif

  // A byte is handed over only when none is outstanding and the UART is idle;
  // a completion pulse only counts while our byte is outstanding.
  assign issue_now = in_send && !issued && !i_Tx_Active;
  assign done_now  = in_send && issued && i_Tx_Done;

  // Select the byte the current send state wants on the line.
  always_comb begin
    cur_byte = 8'h00;
    case (state)
      SEND_SOF:  cur_byte = SOF;
      SEND_LEN:  cur_byte = len_byte;
      SEND_DATA: cur_byte = mem[rd_idx[AW-1:0]];
`ifdef UART_FRAMER_CHECKSUM_EN
      SEND_CHK:  cur_byte = chk;
`endif
      default:   cur_byte = 8'h00;
    endcase
  end

  // Payload buffer write; contents need no reset since wr_cnt bounds reads.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      mem[wr_cnt[AW-1:0]] <= i_data;
    end
  end

  // Frame FSM, per-byte issue/complete handshake and registered TX outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= COLLECT;
      wr_cnt  <= '0;
      rd_idx  <= '0;
      issued  <= 1'b0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
`ifdef UART_FRAMER_CHECKSUM_EN
      chk     <= 8'h00;
`endif
    end else begin
      tx_dv <= 1'b0;
      if (issue_now) begin
        tx_dv   <= 1'b1;
        tx_byte <= cur_byte;
        issued  <= 1'b1;
`ifdef UART_FRAMER_CHECKSUM_EN
        if (state == SEND_LEN || state == SEND_DATA) begin
          chk <= chk + cur_byte;
        end
`endif
      end
      if (done_now) begin
        issued <= 1'b0;
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            // A full buffer closes the packet even without i_last.
            if (i_last || wr_cnt == LAST_CNT) begin
              state <= SEND_SOF;
            end
          end
        end
        SEND_SOF: begin
          if (done_now) state <= SEND_LEN;
        end
        SEND_LEN: begin
          if (done_now) state <= SEND_DATA;
        end
        SEND_DATA: begin
          if (done_now) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx + 1'b1 == wr_cnt) begin
              state <= AFTER_DATA;
            end
          end
        end
`ifdef UART_FRAMER_CHECKSUM_EN
        SEND_CHK: begin
          if (done_now) state <= DONE;
        end
`endif
        DONE: begin
          wr_cnt <= '0;
          rd_idx <= '0;
`ifdef UART_FRAMER_CHECKSUM_EN
          chk    <= 8'h00;
`endif
          state  <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign o_ready   = (state == COLLECT);
  assign o_busy    = (state != COLLECT);
  assign o_Tx_DV   = tx_dv;
  assign o_Tx_Byte = tx_byte;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed bench for uart_tx_framer with a UART TX
// responder, a frame-level reference model and a byte scoreboard.
module tb_uart_tx_framer;

  localparam int         DEPTH   = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TX_BUSY = 10;
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam int         OVH     = 3;
`else
  localparam int         OVH     = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk_tb;
  logic reset_n;
  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       o_busy;
  logic [2:0] dbg_state;

  uart_tx_framer #(.DEPTH(DEPTH), .SOF(SOF)) dut (
    .clk         (clk_tb),
    .reset_n     (reset_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_busy      (o_busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int         total = 0;
  int         bad = 0;
  int         dv_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] lit_q[$];
  bit         mon_en = 0;
  bit         hold_active = 0;
  int         spur_cnt = 0;
  logic [2:0] idle_state;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic string q_str(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Compare the bytes captured since the last clear against a literal frame.
  task automatic check_frame(input string name);
    bit ok;
    total++;
    ok = (got_q.size() == lit_q.size());
    if (ok) foreach (lit_q[i]) if (got_q[i] !== lit_q[i]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=[%s] want=[%s]", name, q_str(got_q), q_str(lit_q));
    end
  endtask

  // ---------------- reference model ----------------
  // Frame = SOF, LEN, payload, and (with checksum) (LEN + sum payload) mod 256.
  task automatic close_packet();
    int sum;
    sum = pay_q.size();
    exp_q.push_back(SOF);
    exp_q.push_back(8'(pay_q.size()));
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      sum += int'(pay_q[i]);
    end
`ifdef UART_FRAMER_CHECKSUM_EN
    exp_q.push_back(8'(sum));
`endif
    pay_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All driver activity happens 2 time units after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    while (!acc && n < 300) begin
      acc = o_ready;
      @(posedge clk_tb);
      #2;
      n++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    cmp("send_accept", acc, 1);
    if (acc) begin
      pay_q.push_back(d);
      if (l || pay_q.size() == DEPTH) close_packet();
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_tb);
    #2;
  endtask

  // Wait for the final completion of a frame, then check the one-cycle DONE
  // gap and the return of o_ready.
  task automatic wait_frame(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 4000 && !seen; n++) begin
      @(posedge clk_tb);
      #2;
      if (i_Tx_Done && exp_q.size() == 0) seen = 1;
    end
    cmp({name, "_finished"}, seen, 1);
    if (seen) begin
      cmp({name, "_ready_in_done"}, o_ready, 0);
      cycles(1);
      cmp({name, "_ready_back"}, o_ready, 1);
      cmp({name, "_idle_state"}, dbg_state, idle_state);
    end
  endtask

  task automatic reset_checks(input string name);
    cmp({name, "_ready"}, o_ready, 1);
    cmp({name, "_dv"}, o_Tx_DV, 0);
    cmp({name, "_busy"}, o_busy, 0);
    cmp({name, "_byte"}, o_Tx_Byte, 8'h00);
  endtask

  // ---------------- TX responder + scoreboard compare ----------------
  // Runs on the falling edge: inputs it drives are seen at the next rising
  // edge, so i_Tx_Active here is what the DUT sampled at the last edge.
  initial begin
    int tx_cnt;
    int spur_seen;
    bit tx_out;
    tx_cnt = 0;
    spur_seen = 0;
    tx_out = 0;
    i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk_tb);
      i_Tx_Done = 1'b0;
      if (mon_en) cmp("ready_vs_busy", o_ready, !o_busy);
      if (mon_en && o_Tx_DV) begin
        dv_count++;
        got_q.push_back(o_Tx_Byte);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dv: got=%02h want=no strobe", o_Tx_Byte);
        end else begin
          cmp("tx_byte", o_Tx_Byte, exp_q.pop_front());
        end
        cmp("dv_while_active", i_Tx_Active, 0);
        cmp("dv_without_done", tx_out, 0);
        cmp("ready_in_frame", o_ready, 0);
        tx_out = 1;
        tx_cnt = TX_BUSY;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_Tx_Done = 1'b1;
          tx_out = 0;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        i_Tx_Done = 1'b1;
      end
      i_Tx_Active = (tx_cnt > 0) || hold_active;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int dv0;
    bit reached;
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
    cycles(3);
    reset_checks("por");
    idle_state = dbg_state;
    reset_n = 1'b1;
    mon_en = 1;
    cycles(2);

    // Reset in mid-collection, then a 1-byte packet.
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    reset_n = 1'b0;
    pay_q.delete();
    cycles(2);
    reset_checks("mid_collect_rst");
    reset_n = 1'b1;
    cycles(1);
    got_q.delete();
    send_byte(8'h5A, 1'b1);
    cmp("busy_state_differs", dbg_state != idle_state, 1);
    wait_frame("one_byte");
    lit_q = {8'hA5, 8'h01, 8'h5A};
`ifdef UART_FRAMER_CHECKSUM_EN
    lit_q.push_back(8'h5B);
`endif
    check_frame("one_byte_frame");

    // Three-byte packet.
    got_q.delete();
    dv0 = dv_count;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_frame("three_byte");
    cmp("three_byte_dv_pulses", dv_count - dv0, OVH + 3);
    lit_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef UART_FRAMER_CHECKSUM_EN
    lit_q.push_back(8'h69);
`endif
    check_frame("three_byte_frame");

    // Forced close on a full buffer.
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == DEPTH - 2) cmp("ready_before_full", o_ready, 1);
    end
    cmp("ready_after_full", o_ready, 0);
    cmp("busy_after_full", o_busy, 1);
    wait_frame("forced");
    lit_q = {8'hA5, 8'h10};
    for (int i = 0; i < DEPTH; i++) lit_q.push_back(8'(i));
`ifdef UART_FRAMER_CHECKSUM_EN
    lit_q.push_back(8'h88);
`endif
    check_frame("forced_frame");

    // UART held busy, plus a stray completion pulse while nothing is issued.
    got_q.delete();
    hold_active = 1;
    cycles(1);
    dv0 = dv_count;
    send_byte(8'h80, 1'b0);
    send_byte(8'h90, 1'b1);
    cycles(10);
    spur_cnt++;
    cycles(40);
    cmp("no_dv_while_held", dv_count - dv0, 0);
    hold_active = 0;
    wait_frame("held");
    lit_q = {8'hA5, 8'h02, 8'h80, 8'h90};
`ifdef UART_FRAMER_CHECKSUM_EN
    lit_q.push_back(8'h12);
`endif
    check_frame("held_frame");

    // Reset while the second payload byte is with the UART.
    got_q.delete();
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b1);
    reached = 0;
    for (int n = 0; n < 500 && !reached; n++) begin
      cycles(1);
      if (got_q.size() >= 4) reached = 1;
    end
    cmp("reach_second_payload", reached, 1);
    reset_n = 1'b0;
    exp_q.delete();
    pay_q.delete();
    cycles(2);
    reset_checks("send_data_rst");
    reset_n = 1'b1;
    dv0 = dv_count;
    cycles(40);
    cmp("no_dv_after_rst", dv_count - dv0, 0);
    lit_q = {8'hA5, 8'h04, 8'hD1, 8'hD2};
    check_frame("aborted_prefix");
    got_q.delete();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    wait_frame("after_abort");
    lit_q = {8'hA5, 8'h02, 8'h77, 8'h88};
`ifdef UART_FRAMER_CHECKSUM_EN
    lit_q.push_back(8'h01);
`endif
    check_frame("after_abort_frame");

    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
